ysyx_25020037_icache: RTL and testbench
=======================================

Name: ysyx_25020037_icache

Overview:
- Direct-mapped, read-only instruction cache that sits between the IFU's fetch path and its AXI refill path.
- The IFU presents the PC on icache_addr and sees a combinational hit and data in the same cycle.
- On a miss, the cache raises mem_req with a block-aligned address. The IFU performs the AXI burst and returns the full block on mem_data with a one-cycle mem_ready pulse; the cache then installs the line.
- The block also provides a fence.i flush and hit/miss performance counters.

Parameters:
- BLOCK_SIZE, 4, line size in bytes; power of two, from 4 to 16.
- NUM_LINES, 16, number of lines; power of two, at least 2.
- OFFSET_W, $clog2(BLOCK_SIZE), byte-offset width (localparam).
- INDEX_W, $clog2(NUM_LINES), index width (localparam).
- TAG_W, 32-OFFSET_W-INDEX_W, tag width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  IFU lookup is live this cycle (IFU idle and idu_ready); qualifies the counters only.
- icache_addr  in  32  fetch PC.
- icache_data  out  32  selected instruction word (combinational).
- icache_hit  out  1  line valid and tag match (combinational).
- icache_ready  out  1  cache is in IDLE.
- mem_req  out  1  refill request.
- mem_addr  out  32  block-aligned refill address.
- mem_data  in  BLOCK_SIZE*8  refill block; word i occupies bits [32i +: 32].
- mem_ready  in  1  one-cycle refill-complete pulse.
- access_fault  in  1  refill error, valid with mem_ready.
- flush  in  1  fence.i pulse; invalidates all lines.
- hit_cnt  out  32  counted hits.
- miss_cnt  out  32  counted misses.

Behaviour:
- Storage:
  - data array NUM_LINES x BLOCK_SIZE*8, tag array NUM_LINES x TAG_W, valid vector NUM_LINES.
  - Only the valid vector is reset (all 0). Data and tag arrays are not reset.
- Address split: tag = addr[31 : OFFSET_W+INDEX_W]; index = addr[OFFSET_W+INDEX_W-1 : OFFSET_W]; word select = addr[OFFSET_W-1 : 2] (constant 0 when BLOCK_SIZE = 4).
- Lookup is purely combinational:
  - icache_hit = valid[idx] & (tag_arr[idx] == tag).
  - icache_data = selected word of data_arr[idx]; undefined unless icache_hit.
- States: IDLE, MISS.
  - IDLE -> MISS when fetch_req & !icache_hit. At that edge, latch miss_tag and miss_idx from icache_addr.
  - MISS -> IDLE on mem_ready. At that same edge:
    - if !access_fault: data_arr[miss_idx] <= mem_data, tag_arr[miss_idx] <= miss_tag, valid[miss_idx] <= 1;
    - if access_fault: nothing is written and valid is unchanged.
  - MISS holds until mem_ready; there is no timeout.
- mem_req = (IDLE & fetch_req & !icache_hit) | MISS.
- mem_addr = {icache_addr[31:OFFSET_W], 0} in IDLE; {miss_tag, miss_idx, 0} in MISS.
- icache_ready = (state == IDLE).
- Latency:
  - Hit: data is available in the same cycle.
  - Miss: the installed line is readable in the cycle after the mem_ready pulse. The IFU re-reads icache_data then.
- mem_ready while in IDLE (spurious): ignored; no write.
- flush:
  - Clears every valid bit at the next edge, in any state.
  - Flush and refill install at the same edge: the flush clears all bits first, then the refilled line is set valid.
  - A flush during MISS does not abort the refill.
- Counters (wrap at 2^32, reset to 0):
  - hit_cnt increments when IDLE & fetch_req & icache_hit.
  - miss_cnt increments on the IDLE -> MISS transition.
- icache_addr changing during MISS does not affect the latched refill target.
- Reset mid-MISS: returns to IDLE with all lines invalid and counters at 0. A later mem_ready is ignored.
- Reset values of registered outputs: hit_cnt = 0, miss_cnt = 0, state = IDLE. Consequently icache_ready = 1, mem_req = fetch_req, icache_hit = 0.

Decomposition:
- Add to the shared config header: ICACHE_BLOCK_SIZE and ICACHE_NUM_LINES defaults, and the state encodings IC_IDLE = 1'b0 and IC_MISS = 1'b1.
- One sub-module is natural: ysyx_25020037_icache_array, holding the data, tag and valid storage. It has a combinational read port (index) and one write port (index, tag, block, wen, flush-all).
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then fetch_req = 1 with icache_addr = 0x30000000 -> icache_hit = 0, mem_req = 1, mem_addr = 0x30000000; next cycle state is MISS and miss_cnt = 1.
- In MISS, pulse mem_ready with mem_data = 0x00100073 and access_fault = 0 -> next cycle icache_hit = 1, icache_data = 0x00100073; on a further fetch_req cycle hit_cnt = 1.
- Install 0x30000000, then look up 0x30000040 (same index for NUM_LINES = 16, BLOCK_SIZE = 4) -> miss. Refill with 0xDEADBEEF -> 0x30000040 hits, and 0x30000000 now misses (conflict eviction).
- Refill 0xA0000000 with access_fault = 1 -> returns to IDLE, 0xA0000000 still misses, mem_req reasserts.
- Install 0x30000004, then assert flush in IDLE -> next cycle icache_hit = 0. Repeat with flush coinciding with mem_ready -> the refilled line is valid and all others are invalid.
- With BLOCK_SIZE = 16, refill 0xA0000010 with words {W3, W2, W1, W0} -> addresses 0xA0000010, 0xA0000014, 0xA0000018 and 0xA000001C return W0 through W3 respectively; miss_cnt increments by 1 only.

Source files
------------

// File: rtl/ysyx_25020037_icache_pkg.sv
// Shared configuration for the instruction cache: default geometry and FSM state encodings.
package ysyx_25020037_icache_pkg;

  localparam int ICACHE_BLOCK_SIZE = 4;
  localparam int ICACHE_NUM_LINES  = 16;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;

  function automatic int ic_words_per_block(input int block_size);
    return block_size / 4;
  endfunction

endpackage

// File: rtl/ysyx_25020037_icache_array.sv
// Line storage for the icache: data/tag arrays with a combinational read port,
// one refill write port and a flush-all that clears every valid bit.
module ysyx_25020037_icache_array #(
  parameter  int NUM_LINES  = 16,
  parameter  int BLOCK_BITS = 32,
  parameter  int TAG_W      = 26,
  localparam int INDEX_W    = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    i_rd_idx,
  output logic [BLOCK_BITS-1:0] o_rd_block,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic                  o_rd_valid,
  input  logic                  i_wen,
  input  logic [INDEX_W-1:0]    i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [BLOCK_BITS-1:0] i_wr_block,
  input  logic                  i_flush
);

  logic [BLOCK_BITS-1:0] r_data [NUM_LINES];
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0]  r_valid;
  logic [NUM_LINES-1:0]  w_valid_next;

  // Data and tags carry no reset; the valid vector alone decides what is usable.
  always_ff @(posedge clk) begin
    if (i_wen) begin
      r_data[i_wr_idx] <= i_wr_block;
      r_tag[i_wr_idx]  <= i_wr_tag;
    end
  end

  // Flush clears first so a refill landing on the same edge survives.
  always_comb begin
    w_valid_next = r_valid;
    if (i_flush) begin
      w_valid_next = '0;
    end
    if (i_wen) begin
      w_valid_next[i_wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
    end
  end

  assign o_rd_block = r_data[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, IDLE/MISS refill FSM,
// fence.i flush and hit/miss counters.
module ysyx_25020037_icache
  import ysyx_25020037_icache_pkg::*;
#(
  parameter int BLOCK_SIZE = ICACHE_BLOCK_SIZE,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [31:0]             icache_addr,
  output logic [31:0]             icache_data,
  output logic                    icache_hit,
  output logic                    icache_ready,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  input  logic                    access_fault,
  input  logic                    flush,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int OFFSET_W   = $clog2(BLOCK_SIZE);
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int TAG_W      = 32 - OFFSET_W - INDEX_W;
  localparam int WORDS      = ic_words_per_block(BLOCK_SIZE);
  localparam int BLOCK_BITS = BLOCK_SIZE * 8;

  ic_state_e r_state, w_state_next;

  logic [TAG_W-1:0]      r_miss_tag;
  logic [INDEX_W-1:0]    r_miss_idx;
  logic [31:0]           r_hit_cnt;
  logic [31:0]           r_miss_cnt;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_idx;
  logic [BLOCK_BITS-1:0] w_rd_block;
  logic [TAG_W-1:0]      w_rd_tag;
  logic                  w_rd_valid;
  logic                  w_miss_start;
  logic                  w_refill;
  logic                  w_hit_count;
  logic                  w_unused_addr;

  assign w_tag         = icache_addr[31 -: TAG_W];
  assign w_idx         = icache_addr[OFFSET_W +: INDEX_W];
  assign w_unused_addr = ^icache_addr[1:0];

  ysyx_25020037_icache_array #(
    .NUM_LINES  (NUM_LINES),
    .BLOCK_BITS (BLOCK_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_idx),
    .o_rd_block (w_rd_block),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .i_wen      (w_refill),
    .i_wr_idx   (r_miss_idx),
    .i_wr_tag   (r_miss_tag),
    .i_wr_block (mem_data),
    .i_flush    (flush)
  );

  assign icache_hit = w_rd_valid & (w_rd_tag == w_tag);

  generate
    if (WORDS == 1) begin : g_single_word
      assign icache_data = w_rd_block[31:0];
    end else begin : g_multi_word
      logic [31:0]         w_words [WORDS];
      logic [OFFSET_W-3:0] w_word_sel;
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign w_words[gi] = w_rd_block[32*gi +: 32];
      end
      assign w_word_sel  = icache_addr[OFFSET_W-1:2];
      assign icache_data = w_words[w_word_sel];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // MISS has no timeout: the IFU's AXI path always answers with mem_ready.
  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_addr     = {icache_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
    w_miss_start = 1'b0;
    w_refill     = 1'b0;
    w_hit_count  = 1'b0;
    case (r_state)
      IC_IDLE: begin
        if (fetch_req) begin
          if (icache_hit) begin
            w_hit_count = 1'b1;
          end else begin
            mem_req      = 1'b1;
            w_miss_start = 1'b1;
            w_state_next = IC_MISS;
          end
        end
      end
      IC_MISS: begin
        mem_req  = 1'b1;
        mem_addr = {r_miss_tag, r_miss_idx, {OFFSET_W{1'b0}}};
        if (mem_ready) begin
          w_state_next = IC_IDLE;
          w_refill     = ~access_fault;
        end
      end
      default: w_state_next = IC_IDLE;
    endcase
  end

  // Refill target is frozen at the miss edge; later PC changes do not redirect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss_tag <= '0;
      r_miss_idx <= '0;
    end else if (w_miss_start) begin
      r_miss_tag <= w_tag;
      r_miss_idx <= w_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_count) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_start) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign icache_ready = (r_state == IC_IDLE);
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// Directed self-checking bench: default 4-byte-line cache plus a 16-byte-line instance.
module tb_ysyx_25020037_icache;

  logic         clk = 1'b0;
  logic         rst;

  logic         fetch_req, mem_ready, access_fault, flush;
  logic [31:0]  icache_addr, mem_data;
  logic [31:0]  icache_data, mem_addr, hit_cnt, miss_cnt;
  logic         icache_hit, icache_ready, mem_req;

  logic         fetch_req2, mem_ready2, access_fault2, flush2;
  logic [31:0]  icache_addr2;
  logic [127:0] mem_data2;
  logic [31:0]  icache_data2, mem_addr2, hit_cnt2, miss_cnt2;
  logic         icache_hit2, icache_ready2, mem_req2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_25020037_icache u_dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .icache_addr  (icache_addr),
    .icache_data  (icache_data),
    .icache_hit   (icache_hit),
    .icache_ready (icache_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .access_fault (access_fault),
    .flush        (flush),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  ysyx_25020037_icache #(.BLOCK_SIZE(16), .NUM_LINES(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req2),
    .icache_addr  (icache_addr2),
    .icache_data  (icache_data2),
    .icache_hit   (icache_hit2),
    .icache_ready (icache_ready2),
    .mem_req      (mem_req2),
    .mem_addr     (mem_addr2),
    .mem_data     (mem_data2),
    .mem_ready    (mem_ready2),
    .access_fault (access_fault2),
    .flush        (flush2),
    .hit_cnt      (hit_cnt2),
    .miss_cnt     (miss_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [31:0] addr);
    fetch_req   = 1'b0;
    icache_addr = addr;
    #1;
  endtask

  // Miss on addr, then answer in the next MISS cycle with a one-cycle mem_ready.
  task automatic refill(input logic [31:0] addr, input logic [31:0] data, input logic fault);
    fetch_req   = 1'b1;
    icache_addr = addr;
    tick();
    fetch_req    = 1'b0;
    mem_data     = data;
    mem_ready    = 1'b1;
    access_fault = fault;
    tick();
    mem_ready    = 1'b0;
    access_fault = 1'b0;
    $display("refill addr=0x%08h data=0x%08h fault=%0d miss_cnt=%0d", addr, data, fault, miss_cnt);
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 0; mem_ready = 0; access_fault = 0; flush = 0;
    icache_addr = 0; mem_data = 0;
    fetch_req2 = 0; mem_ready2 = 0; access_fault2 = 0; flush2 = 0;
    icache_addr2 = 0; mem_data2 = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_ready", icache_ready, 1);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_mem_req", mem_req, 0);

    // First miss
    fetch_req = 1'b1; icache_addr = 32'h3000_0000; #1;
    chk("m1_hit", icache_hit, 0);
    chk("m1_mem_req", mem_req, 1);
    chk("m1_mem_addr", mem_addr, 32'h3000_0000);
    tick();
    chk("m1_ready", icache_ready, 0);
    chk("m1_miss_cnt", miss_cnt, 1);
    icache_addr = 32'h1234_5678; #1;
    chk("m1_latched_addr", mem_addr, 32'h3000_0000);
    chk("m1_req_in_miss", mem_req, 1);
    tick();
    chk("m1_hold_miss", icache_ready, 0);
    chk("m1_no_recount", miss_cnt, 1);
    mem_data = 32'h0010_0073; mem_ready = 1'b1; fetch_req = 1'b0;
    tick();
    mem_ready = 1'b0;
    $display("refill addr=0x30000000 data=0x00100073 fault=0 miss_cnt=%0d", miss_cnt);
    probe(32'h3000_0000);
    chk("m1_fill_hit", icache_hit, 1);
    chk("m1_fill_data", icache_data, 32'h0010_0073);
    chk("m1_ready_back", icache_ready, 1);
    chk("m1_hit_cnt0", hit_cnt, 0);
    fetch_req = 1'b1; #1;
    chk("m1_hit_no_req", mem_req, 0);
    tick();
    chk("m1_hit_cnt1", hit_cnt, 1);

    // Conflict eviction on index 0
    probe(32'h3000_0040);
    chk("cf_miss", icache_hit, 0);
    refill(32'h3000_0040, 32'hDEAD_BEEF, 1'b0);
    chk("cf_miss_cnt", miss_cnt, 2);
    probe(32'h3000_0040);
    chk("cf_new_hit", icache_hit, 1);
    chk("cf_new_data", icache_data, 32'hDEAD_BEEF);
    probe(32'h3000_0000);
    chk("cf_old_evicted", icache_hit, 0);

    // Faulted refill writes nothing
    refill(32'hA000_0000, 32'h5555_5555, 1'b1);
    chk("af_ready", icache_ready, 1);
    probe(32'hA000_0000);
    chk("af_still_miss", icache_hit, 0);
    probe(32'h3000_0040);
    chk("af_keep_line", icache_hit, 1);
    fetch_req = 1'b1; icache_addr = 32'hA000_0000; #1;
    chk("af_req_again", mem_req, 1);
    chk("af_req_addr", mem_addr, 32'hA000_0000);
    fetch_req = 1'b0;

    // Spurious mem_ready in IDLE
    probe(32'hA000_0000);
    mem_ready = 1'b1; mem_data = 32'h7777_7777;
    tick();
    mem_ready = 1'b0;
    chk("sp_no_write", icache_hit, 0);
    chk("sp_idle", icache_ready, 1);

    // Flush in IDLE
    refill(32'h3000_0004, 32'h1111_1111, 1'b0);
    probe(32'h3000_0004);
    chk("fl_pre_hit", icache_hit, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    probe(32'h3000_0004);
    chk("fl_cleared", icache_hit, 0);
    probe(32'h3000_0040);
    chk("fl_cleared_other", icache_hit, 0);

    // Flush coinciding with refill install
    refill(32'h3000_0008, 32'h2222_2222, 1'b0);
    fetch_req = 1'b1; icache_addr = 32'h3000_000C;
    tick();
    fetch_req = 1'b0; mem_data = 32'h3333_3333; mem_ready = 1'b1; flush = 1'b1;
    tick();
    mem_ready = 1'b0; flush = 1'b0;
    probe(32'h3000_000C);
    chk("flr_line_valid", icache_hit, 1);
    chk("flr_line_data", icache_data, 32'h3333_3333);
    probe(32'h3000_0008);
    chk("flr_other_gone", icache_hit, 0);

    // Flush during MISS does not abort the refill
    fetch_req = 1'b1; icache_addr = 32'h3000_0010;
    tick();
    fetch_req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flm_still_miss", icache_ready, 0);
    mem_data = 32'h4444_4444; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    probe(32'h3000_0010);
    chk("flm_hit", icache_hit, 1);
    chk("flm_data", icache_data, 32'h4444_4444);
    probe(32'h3000_000C);
    chk("flm_prev_gone", icache_hit, 0);

    // Asynchronous reset mid-MISS
    fetch_req = 1'b1; icache_addr = 32'h3000_0020;
    tick();
    fetch_req = 1'b0;
    chk("rm_in_miss", icache_ready, 0);
    #2 rst = 1'b1; #1;
    chk("rm_async_ready", icache_ready, 1);
    chk("rm_miss_cnt", miss_cnt, 0);
    chk("rm_hit_cnt", hit_cnt, 0);
    tick();
    rst = 1'b0;
    mem_data = 32'h6666_6666; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    probe(32'h3000_0020);
    chk("rm_late_ready_ignored", icache_hit, 0);
    probe(32'h3000_0010);
    chk("rm_lines_invalid", icache_hit, 0);

    // 16-byte line instance
    fetch_req2 = 1'b1; icache_addr2 = 32'hA000_0010; #1;
    chk("b16_req", mem_req2, 1);
    chk("b16_req_addr", mem_addr2, 32'hA000_0010);
    tick();
    fetch_req2 = 1'b0;
    mem_data2  = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    mem_ready2 = 1'b1;
    tick();
    mem_ready2 = 1'b0;
    $display("refill16 addr=0xa0000010 miss_cnt=%0d", miss_cnt2);
    fetch_req2 = 1'b1;
    icache_addr2 = 32'hA000_0010; #1;
    chk("b16_w0_hit", icache_hit2, 1);
    chk("b16_w0", icache_data2, 32'h1111_0000);
    tick();
    icache_addr2 = 32'hA000_0014; #1;
    chk("b16_w1_hit", icache_hit2, 1);
    chk("b16_w1", icache_data2, 32'h2222_0001);
    tick();
    icache_addr2 = 32'hA000_0018; #1;
    chk("b16_w2_hit", icache_hit2, 1);
    chk("b16_w2", icache_data2, 32'h3333_0002);
    tick();
    icache_addr2 = 32'hA000_001C; #1;
    chk("b16_w3_hit", icache_hit2, 1);
    chk("b16_w3", icache_data2, 32'h4444_0003);
    tick();
    fetch_req2 = 1'b0;
    chk("b16_miss_cnt", miss_cnt2, 1);
    chk("b16_hit_cnt", hit_cnt2, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
